vending_machine_core: RTL and testbench

// Drink vending controller. Accumulates coin credit in cents, sells water/soda/juice on button request,

---
 rtl/vending_machine_core.sv | 132 +++++++++++++
 tb/tb_vending_machine_core.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vending_machine_core.sv
// vending_machine_core
// Drink vending controller: accumulates coin credit, sells water/soda/juice
// on request, drives a timed dispense pulse and refunds unusable leftover
// credit as a timed change pulse.
//
// Ports
//   clk           in   system clock, rising edge
//   rst           in   asynchronous reset, active low
//   coin_in       in   [7:0] coin value in cents, 0 = no coin
//   button_in     in   [1:0] 0 water(30), 1 soda(50), 2 juice(100), 3 none
//   change_out    out  [7:0] refunded cents while in CHANGE, else 0
//   beverage_out  out  [1:0] 0 none, 1 water, 2 soda, 3 juice (DISPENSE only)
//   credit        out  [7:0] current credit, cents
//   state         out  [1:0] 0 IDLE, 1 DISPENSE, 2 CHANGE
//
// state    | meaning
// IDLE     | accept coins, evaluate button request each cycle
// DISPENSE | beverage_out held for N cycles
// CHANGE   | change_out holds refunded credit for M cycles
module vending_machine_core #(
  parameter int N = 3,
  parameter int M = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] coin_in,
  input  logic [1:0] button_in,
  output logic [7:0] change_out,
  output logic [1:0] beverage_out,
  output logic [7:0] credit,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DISPENSE = 2'd1,
    CHANGE   = 2'd2
  } state_t;

  localparam logic [15:0] DISP_LOAD = 16'(N - 1);
  localparam logic [15:0] CHG_LOAD  = 16'(M - 1);
  localparam logic [7:0]  MIN_PRICE = 8'd30;

  state_t      state_q;
  logic [15:0] timer;
  logic        coin_ok;
  logic [7:0]  coin_add;
  logic [7:0]  price;
  logic        buy;
  logic [7:0]  credit_buy;

  assign state = state_q;

  always_comb begin
    coin_ok = 1'b0;
    case (coin_in)
      8'd5, 8'd10, 8'd20, 8'd50, 8'd100, 8'd200:
        // Saturation is judged against the credit before any purchase.
        coin_ok = ({1'b0, credit} + {1'b0, coin_in}) <= 9'd255;
      default: coin_ok = 1'b0;
    endcase
    coin_add = coin_ok ? coin_in : 8'd0;

    case (button_in)
      2'd0:    price = 8'd30;
      2'd1:    price = 8'd50;
      default: price = 8'd100;
    endcase

    buy        = (button_in != 2'd3) && (credit >= price);
    // Cannot overflow: credit + coin_add <= 255 and price <= credit.
    credit_buy = credit - price + coin_add;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      credit       <= 8'd0;
      beverage_out <= 2'd0;
      change_out   <= 8'd0;
      timer        <= 16'd0;
    end else begin
      case (state_q)
        IDLE: begin
          beverage_out <= 2'd0;
          change_out   <= 8'd0;
          if (buy) begin
            credit       <= credit_buy;
            beverage_out <= button_in + 2'd1;
            timer        <= DISP_LOAD;
            state_q      <= DISPENSE;
          end else begin
            credit <= credit + coin_add;
          end
        end

        DISPENSE: begin
          if (timer == 16'd0) begin
            beverage_out <= 2'd0;
            if (credit != 8'd0 && credit < MIN_PRICE) begin
              change_out <= credit;
              credit     <= 8'd0;
              timer      <= CHG_LOAD;
              state_q    <= CHANGE;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            timer <= timer - 16'd1;
          end
        end

        CHANGE: begin
          if (timer == 16'd0) begin
            change_out <= 8'd0;
            state_q    <= IDLE;
          end else begin
            timer <= timer - 16'd1;
          end
        end

        default: begin
          state_q      <= IDLE;
          beverage_out <= 2'd0;
          change_out   <= 8'd0;
          timer        <= 16'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vending_machine_core.sv
module tb_vending_machine_core;

  localparam int N = 3;
  localparam int M = 2;

  logic       clk;
  logic       rst;
  logic [7:0] coin_in;
  logic [1:0] button_in;
  logic [7:0] change_out;
  logic [1:0] beverage_out;
  logic [7:0] credit;
  logic [1:0] state;

  int errors = 0;
  int checks = 0;

  vending_machine_core #(.N(N), .M(M)) dut (
    .clk          (clk),
    .rst          (rst),
    .coin_in      (coin_in),
    .button_in    (button_in),
    .change_out   (change_out),
    .beverage_out (beverage_out),
    .credit       (credit),
    .state        (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a schedule of future visible outputs. A purchase pushes
  // the whole dispense (and optional refund) episode; while the schedule
  // is being played out the machine is busy and ignores inputs.
  typedef struct {
    int st;
    int bev;
    int chg;
    int cr;
  } exp_t;

  exp_t cur;
  exp_t sched[$];
  int   m_credit;

  function automatic int price_of(int sel);
    if (sel == 0) return 30;
    if (sel == 1) return 50;
    return 100;
  endfunction

  function automatic logic [19:0] exp_vec();
    return {2'(cur.st), 2'(cur.bev), 8'(cur.chg), 8'(cur.cr)};
  endfunction

  task automatic model_reset();
    sched.delete();
    m_credit = 0;
    cur = '{0, 0, 0, 0};
  endtask

  task automatic model_edge(int coin, int btn);
    int add;
    int c;
    add = 0;
    c = m_credit;
    if (cur.st != 0) begin
      if (sched.size() > 0) cur = sched.pop_front();
      else cur = '{0, 0, 0, m_credit};
    end else begin
      if ((coin == 5 || coin == 10 || coin == 20 || coin == 50 ||
           coin == 100 || coin == 200) && (c + coin <= 255))
        add = coin;
      if (btn != 3 && c >= price_of(btn)) begin
        c = c - price_of(btn) + add;
        for (int i = 0; i < N; i++) sched.push_back('{1, btn + 1, 0, c});
        if (c > 0 && c < 30) begin
          for (int i = 0; i < M; i++) sched.push_back('{2, 0, c, 0});
          c = 0;
        end
        m_credit = c;
        cur = sched.pop_front();
      end else begin
        m_credit = c + add;
        cur = '{0, 0, 0, m_credit};
      end
    end
  endtask

  task automatic step(int coin, int btn);
    coin_in   = 8'(coin);
    button_in = 2'(btn);
    @(posedge clk);
    model_edge(coin, btn);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    coin_in   = 8'd0;
    button_in = 2'd3;
    rst = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({state, beverage_out, change_out, credit} !== 20'd0) begin
      errors++;
      $display("FAIL reset_outputs: got st=%0d bev=%0d chg=%0d cr=%0d, want all 0",
               state, beverage_out, change_out, credit);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_no_purchase();
    step(20, 3);
    checks++;
    if (credit !== 8'd20) begin
      errors++;
      $display("FAIL no_buy_credit: got %0d want 20", credit);
    end
    step(0, 0);
    checks++;
    if ({state, beverage_out, credit} !== {2'd0, 2'd0, 8'd20}) begin
      errors++;
      $display("FAIL no_buy_ignored: got st=%0d bev=%0d cr=%0d want 0 0 20",
               state, beverage_out, credit);
    end
  endtask

  task automatic test_water_exact();
    int bev_cycles;
    int saw_change;
    bev_cycles = 0;
    saw_change = 0;
    step(10, 0);
    step(0, 0);
    checks++;
    if ({state, beverage_out, credit} !== {2'd1, 2'd1, 8'd0}) begin
      errors++;
      $display("FAIL water_start: got st=%0d bev=%0d cr=%0d want 1 1 0",
               state, beverage_out, credit);
    end
    bev_cycles = 1;
    for (int i = 0; i < 8; i++) begin
      step(0, 3);
      if (beverage_out == 2'd1) bev_cycles++;
      if (state == 2'd2) saw_change = 1;
    end
    checks++;
    if (bev_cycles != N || saw_change != 0 || state !== 2'd0) begin
      errors++;
      $display("FAIL water_pulse: got cycles=%0d change=%0d st=%0d want %0d 0 0",
               bev_cycles, saw_change, state, N);
    end
  endtask

  task automatic test_soda_then_water();
    do_reset();
    step(200, 3);
    step(0, 1);
    checks++;
    if ({beverage_out, credit} !== {2'd2, 8'd150}) begin
      errors++;
      $display("FAIL soda_start: got bev=%0d cr=%0d want 2 150", beverage_out, credit);
    end
    for (int i = 0; i < N; i++) step(0, 3);
    checks++;
    if ({state, beverage_out, credit} !== {2'd0, 2'd0, 8'd150}) begin
      errors++;
      $display("FAIL soda_end: got st=%0d bev=%0d cr=%0d want 0 0 150",
               state, beverage_out, credit);
    end
    step(0, 0);
    checks++;
    if ({beverage_out, credit} !== {2'd1, 8'd120}) begin
      errors++;
      $display("FAIL soda_water: got bev=%0d cr=%0d want 1 120", beverage_out, credit);
    end
    for (int i = 0; i < N; i++) step(0, 3);
    checks++;
    if ({state, change_out, credit} !== {2'd0, 8'd0, 8'd120}) begin
      errors++;
      $display("FAIL soda_water_end: got st=%0d chg=%0d cr=%0d want 0 0 120",
               state, change_out, credit);
    end
  endtask

  task automatic test_change();
    int chg_cycles;
    chg_cycles = 0;
    do_reset();
    step(20, 3);
    step(20, 3);
    step(0, 1);
    checks++;
    if ({state, credit} !== {2'd0, 8'd40}) begin
      errors++;
      $display("FAIL change_soda_ignored: got st=%0d cr=%0d want 0 40", state, credit);
    end
    step(0, 0);
    checks++;
    if ({beverage_out, credit} !== {2'd1, 8'd10}) begin
      errors++;
      $display("FAIL change_water: got bev=%0d cr=%0d want 1 10", beverage_out, credit);
    end
    for (int i = 0; i < N + M + 2; i++) begin
      step(0, 3);
      if (state == 2'd2 && change_out == 8'd10) chg_cycles++;
    end
    checks++;
    if (chg_cycles != M || {state, change_out, credit} !== 18'd0) begin
      errors++;
      $display("FAIL change_pulse: got cycles=%0d st=%0d chg=%0d cr=%0d want %0d 0 0 0",
               chg_cycles, state, change_out, credit, M);
    end
  endtask

  task automatic test_reject();
    do_reset();
    step(7, 3);
    step(255, 3);
    checks++;
    if (credit !== 8'd0) begin
      errors++;
      $display("FAIL reject_invalid: got %0d want 0", credit);
    end
    step(200, 3);
    step(50, 3);
    step(10, 3);
    checks++;
    if (credit !== 8'd250) begin
      errors++;
      $display("FAIL reject_saturate: got %0d want 250", credit);
    end
    step(5, 3);
    checks++;
    if (credit !== 8'd255) begin
      errors++;
      $display("FAIL accept_to_255: got %0d want 255", credit);
    end
    step(0, 2);
    step(50, 3);
    checks++;
    if ({state, beverage_out, credit} !== {2'd1, 2'd3, 8'd155}) begin
      errors++;
      $display("FAIL coin_in_dispense: got st=%0d bev=%0d cr=%0d want 1 3 155",
               state, beverage_out, credit);
    end
    for (int i = 0; i < N; i++) step(0, 3);
  endtask

  task automatic test_back_to_back();
    int bev_cycles;
    bev_cycles = 0;
    do_reset();
    step(100, 3);
    step(50, 3);
    for (int i = 0; i < 24; i++) begin
      step(0, 0);
      if (beverage_out == 2'd1) bev_cycles++;
      checks++;
      if ({state, beverage_out, change_out, credit} !== exp_vec()) begin
        errors++;
        $display("FAIL back_to_back cyc%0d: got %h want %h", i,
                 {state, beverage_out, change_out, credit}, exp_vec());
      end
    end
    checks++;
    if (bev_cycles != 5 * N || credit !== 8'd0) begin
      errors++;
      $display("FAIL back_to_back_total: got cycles=%0d cr=%0d want %0d 0",
               bev_cycles, credit, 5 * N);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    step(50, 3);
    step(0, 0);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({state, beverage_out, change_out, credit} !== 20'd0) begin
      errors++;
      $display("FAIL reset_mid: got st=%0d bev=%0d chg=%0d cr=%0d want all 0",
               state, beverage_out, change_out, credit);
    end
    model_reset();
    coin_in   = 8'd0;
    button_in = 2'd3;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_random();
    int coins[12] = '{0, 0, 0, 5, 10, 20, 50, 100, 200, 7, 255, 30};
    int c;
    int b;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      c = coins[$urandom_range(0, 11)];
      b = int'($urandom_range(0, 6));
      if (b > 3) b = 3;
      step(c, b);
      checks++;
      if ({state, beverage_out, change_out, credit} !== exp_vec()) begin
        errors++;
        $display("FAIL random cyc%0d: got st=%0d bev=%0d chg=%0d cr=%0d want %0d %0d %0d %0d",
                 i, state, beverage_out, change_out, credit,
                 cur.st, cur.bev, cur.chg, cur.cr);
      end
    end
  endtask

  initial begin
    rst       = 1'b0;
    coin_in   = 8'd0;
    button_in = 2'd3;
    test_reset();
    test_no_purchase();
    test_water_exact();
    test_soda_then_water();
    test_change();
    test_reject();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
